// File: rtl/grid_pkg.sv
// Shared types, default geometry and colour constants for the cell-grid renderer.
package grid_pkg;

  localparam int unsigned DEF_COLS         = 64;
  localparam int unsigned DEF_ROWS         = 48;
  localparam int unsigned DEF_CELL_W       = 10;
  localparam int unsigned DEF_CELL_H       = 10;
  localparam int unsigned DEF_BLINK_FRAMES = 30;
  localparam int unsigned PIX_W            = 10;

  // 12-bit {r,g,b} pixel colour
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;
  localparam rgb_t RGB_RED   = 12'hF00;
  localparam rgb_t RGB_GREY  = 12'h444;

  // Bits needed to index n items (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grid_renderer_if.sv
// Pixel stream in from the sync generator and RGB/sync stream out to the pins.
interface grid_renderer_if;
  import grid_pkg::*;

  logic             pix_en;
  logic             video_on;
  logic [PIX_W-1:0] x;
  logic [PIX_W-1:0] y;
  logic             hsync_in;
  logic             vsync_in;
  logic [3:0]       r;
  logic [3:0]       g;
  logic [3:0]       b;
  logic             hsync_out;
  logic             vsync_out;

  modport master (
    output pix_en, video_on, x, y, hsync_in, vsync_in,
    input  r, g, b, hsync_out, vsync_out
  );

  modport slave (
    input  pix_en, video_on, x, y, hsync_in, vsync_in,
    output r, g, b, hsync_out, vsync_out
  );

endinterface

// File: rtl/grid_cell_tracker.sv
// Stage 1: maps the incrementing (x, y) stream to cell column/row, in-cell
// offsets and the row base index using running counters only.
module grid_cell_tracker
  import grid_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned CELL_W = DEF_CELL_W,
  parameter int unsigned CELL_H = DEF_CELL_H
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pix_en,
  input  logic                                 video_on,
  input  logic [PIX_W-1:0]                     x,
  input  logic [PIX_W-1:0]                     y,
  input  logic                                 hsync_in,
  input  logic                                 vsync_in,
  output logic                                 video_on_d,
  output logic                                 hsync_d,
  output logic                                 vsync_d,
  output logic [idx_width(COLS+1)-1:0]         col,
  output logic [idx_width(ROWS+1)-1:0]         row,
  output logic [idx_width(CELL_W)-1:0]         sub_x,
  output logic [idx_width(CELL_H)-1:0]         sub_y,
  output logic [idx_width(COLS*ROWS+1)-1:0]    base,
  output logic                                 in_grid
);

  localparam int unsigned COL_W  = idx_width(COLS + 1);
  localparam int unsigned ROW_W  = idx_width(ROWS + 1);
  localparam int unsigned SX_W   = idx_width(CELL_W);
  localparam int unsigned SY_W   = idx_width(CELL_H);
  localparam int unsigned BASE_W = idx_width(COLS * ROWS + 1);

  logic [COL_W-1:0]  col_n;
  logic [ROW_W-1:0]  row_n;
  logic [SX_W-1:0]   sub_x_n;
  logic [SY_W-1:0]   sub_y_n;
  logic [BASE_W-1:0] base_n;
  logic              in_grid_n;

  // Next counter values; col/row saturate at COLS/ROWS as the off-grid marker
  always_comb begin
    col_n   = col;
    row_n   = row;
    sub_x_n = sub_x;
    sub_y_n = sub_y;
    base_n  = base;

    if (x == '0) begin
      col_n   = '0;
      sub_x_n = '0;
    end else if (sub_x == SX_W'(CELL_W - 1)) begin
      sub_x_n = '0;
      if (col != COL_W'(COLS)) col_n = col + COL_W'(1);
    end else begin
      sub_x_n = sub_x + SX_W'(1);
    end

    if (x == '0) begin
      if (y == '0) begin
        row_n   = '0;
        sub_y_n = '0;
        base_n  = '0;
      end else if (sub_y == SY_W'(CELL_H - 1)) begin
        sub_y_n = '0;
        if (row != ROW_W'(ROWS)) begin
          row_n  = row + ROW_W'(1);
          base_n = base + BASE_W'(COLS);
        end
      end else begin
        sub_y_n = sub_y + SY_W'(1);
      end
    end

    in_grid_n = (col_n < COL_W'(COLS)) && (row_n < ROW_W'(ROWS));
  end

  // Stage-1 pipeline register; reset parks the tracker off-grid
  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= COL_W'(COLS);
      row        <= ROW_W'(ROWS);
      sub_x      <= '0;
      sub_y      <= '0;
      base       <= '0;
      in_grid    <= 1'b0;
      video_on_d <= 1'b0;
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
    end else if (pix_en) begin
      col        <= col_n;
      row        <= row_n;
      sub_x      <= sub_x_n;
      sub_y      <= sub_y_n;
      base       <= base_n;
      in_grid    <= in_grid_n;
      video_on_d <= video_on;
      hsync_d    <= hsync_in;
      vsync_d    <= vsync_in;
    end
  end

endmodule

// File: rtl/grid_renderer.sv
// Two-stage Game of Life board renderer: cell tracking, then colour select
// with blinking cursor. Optional macro GRID_LINES_EN draws the first pixel
// column/row of every cell in GRID_RGB.
module grid_renderer
  import grid_pkg::*;
#(
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned CELL_W       = DEF_CELL_W,
  parameter int unsigned CELL_H       = DEF_CELL_H,
  parameter rgb_t        ALIVE_RGB    = RGB_WHITE,
  parameter rgb_t        DEAD_RGB     = RGB_BLACK,
  parameter rgb_t        CURSOR_RGB   = RGB_RED,
  parameter rgb_t        GRID_RGB     = RGB_GREY,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                         clk,
  input  logic                         reset,
  grid_renderer_if.slave               pix,
  input  logic [0:COLS*ROWS-1]         cells,
  input  logic                         cursor_en,
  input  logic [idx_width(COLS)-1:0]   cursor_col,
  input  logic [idx_width(ROWS)-1:0]   cursor_row
);

  localparam int unsigned COL_W  = idx_width(COLS + 1);
  localparam int unsigned ROW_W  = idx_width(ROWS + 1);
  localparam int unsigned SX_W   = idx_width(CELL_W);
  localparam int unsigned SY_W   = idx_width(CELL_H);
  localparam int unsigned BASE_W = idx_width(COLS * ROWS + 1);
  localparam int unsigned IDX_W  = idx_width(COLS * ROWS);
  localparam int unsigned BF_W   = idx_width(BLINK_FRAMES);

  logic              video_on_d;
  logic              hsync_d;
  logic              vsync_d;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [SX_W-1:0]   sub_x;
  logic [SY_W-1:0]   sub_y;
  logic [BASE_W-1:0] base;
  logic              in_grid;

  logic              frame_start;
  logic              frame_seen;
  logic [BF_W-1:0]   frame_cnt;
  logic              blink_on;

  logic [IDX_W-1:0]  cell_idx;
  logic              cursor_hit;
  rgb_t              rgb_n;
  rgb_t              rgb_q;
  logic              hsync_q;
  logic              vsync_q;

  grid_cell_tracker #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CELL_W (CELL_W),
    .CELL_H (CELL_H)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix.pix_en),
    .video_on   (pix.video_on),
    .x          (pix.x),
    .y          (pix.y),
    .hsync_in   (pix.hsync_in),
    .vsync_in   (pix.vsync_in),
    .video_on_d (video_on_d),
    .hsync_d    (hsync_d),
    .vsync_d    (vsync_d),
    .col        (col),
    .row        (row),
    .sub_x      (sub_x),
    .sub_y      (sub_y),
    .base       (base),
    .in_grid    (in_grid)
  );

  // A frame begins on the strobe carrying pixel (0,0)
  always_comb frame_start = pix.pix_en && (pix.x == '0) && (pix.y == '0);

  // Blink timer: the first frame start after reset opens frame 0, later
  // starts close a frame, so every half-period is exactly BLINK_FRAMES long
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_seen <= 1'b0;
      frame_cnt  <= '0;
      blink_on   <= 1'b1;
    end else if (frame_start) begin
      if (!frame_seen) begin
        frame_seen <= 1'b1;
      end else if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + BF_W'(1);
      end
    end
  end

  // Stage-2 colour priority: blank/off-grid, grid line, cursor, cell state
  always_comb begin
    cell_idx   = '0;
    cursor_hit = 1'b0;
    rgb_n      = RGB_BLACK;

    if (in_grid) cell_idx = IDX_W'(base + BASE_W'(col));
    cursor_hit = cursor_en && blink_on &&
                 (col == COL_W'(cursor_col)) && (row == ROW_W'(cursor_row));

    if (!video_on_d || !in_grid) begin
      rgb_n = RGB_BLACK;
`ifdef GRID_LINES_EN
    end else if ((sub_x == '0) || (sub_y == '0)) begin
      rgb_n = GRID_RGB;
`endif
    end else if (cursor_hit) begin
      rgb_n = CURSOR_RGB;
    end else if (cells[cell_idx]) begin
      rgb_n = ALIVE_RGB;
    end else begin
      rgb_n = DEAD_RGB;
    end
  end

`ifndef GRID_LINES_EN
  // Cell offsets and grid colour only matter when grid lines are drawn
  logic unused_grid;
  assign unused_grid = ^{sub_x, sub_y, GRID_RGB};
`endif

  // Output register; holds while pix_en is low
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= RGB_BLACK;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix.pix_en) begin
      rgb_q   <= rgb_n;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix.r         = rgb_q.r;
  assign pix.g         = rgb_q.g;
  assign pix.b         = rgb_q.b;
  assign pix.hsync_out = hsync_q;
  assign pix.vsync_out = vsync_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Randomised frame-level bench for grid_renderer on a reduced 8x6 board of
// 4x3 cells inside a 40x22 active area (44x24 total raster).
module tb_grid_renderer;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int CW   = 4;
  localparam int CH   = 3;
  localparam int BF   = 2;
  localparam int GW   = COLS * CW;
  localparam int GH   = ROWS * CH;
  localparam int HA   = 40;
  localparam int HT   = 44;
  localparam int VA   = 22;
  localparam int VT   = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grid_renderer_if pix ();
  logic [0:COLS*ROWS-1] cells;
  logic                 cursor_en;
  logic [2:0]           cursor_col;
  logic [2:0]           cursor_row;

  grid_renderer #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .CELL_W       (CW),
    .CELL_H       (CH),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix        (pix),
    .cells      (cells),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  int total = 0;
  int bad   = 0;

  // Observed/expected {rgb, hsync, vsync} per clock, and rendered image per pixel
  logic [13:0] obs_q[$];
  logic [13:0] exp_q[$];
  logic [11:0] img [VT][HT];

  // Reference model state
  int          frame_idx = -1;
  logic [13:0] exp_d1    = 14'h3;
  logic [13:0] exp_out   = 14'h3;
  int          px, py;
  bit          prevv     = 1'b0;

  // Colour a pixel straight from the board geometry
  function automatic logic [11:0] model_rgb(input int x, input int y, input bit vid, input int fidx);
    int col, row;
    bit blink;
    if (!vid || fidx < 0 || x >= GW || y >= GH) return 12'h000;
    col = x / CW;
    row = y / CH;
`ifdef GRID_LINES_EN
    if ((x % CW) == 0 || (y % CH) == 0) return 12'h444;
`endif
    blink = ((fidx / BF) % 2) == 0;
    if (cursor_en && blink && col == int'(cursor_col) && row == int'(cursor_row)) return 12'hF00;
    return cells[row*COLS + col] ? 12'hFFF : 12'h000;
  endfunction

  // One clock: drive a raster position, sample after the edge, advance the model
  task automatic step(input bit rst, input bit pen, input int x, input int y);
    bit vid, hs, vs;
    logic [13:0] obs;
    vid = (x < HA) && (y < VA);
    hs  = !((x >= HA + 1) && (x < HA + 3));
    vs  = !(y == VA + 1);
    reset        = rst;
    pix.pix_en   = pen;
    pix.x        = 10'(x);
    pix.y        = 10'(y);
    pix.video_on = vid;
    pix.hsync_in = hs;
    pix.vsync_in = vs;
    @(posedge clk);
    #1;
    obs = {pix.r, pix.g, pix.b, pix.hsync_out, pix.vsync_out};
    if (rst) begin
      frame_idx = -1;
      exp_d1    = 14'h3;
      exp_out   = 14'h3;
      prevv     = 1'b0;
    end else if (pen) begin
      if (x == 0 && y == 0) frame_idx++;
      exp_out = exp_d1;
      if (prevv) img[py][px] = obs[13:2];
      exp_d1 = {model_rgb(x, y, vid, frame_idx), hs, vs};
      px = x;
      py = y;
      prevv = 1'b1;
    end
    obs_q.push_back(obs);
    exp_q.push_back(exp_out);
  endtask

  // Stream one raster; optional pix_en gaps and an optional reset at (rx, ry)
  task automatic run_frame(input bit gaps, input int rx, input int ry);
    foreach (img[a, b]) img[a][b] = 12'hxxx;
    for (int yy = 0; yy < VT; yy++) begin
      for (int xx = 0; xx < HT; xx++) begin
        if (xx == rx && yy == ry) begin
          step(1'b1, 1'b1, xx, yy);
        end else begin
          bit pen;
          do begin
            pen = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b0, pen, xx, yy);
          end while (!pen);
        end
      end
    end
  endtask

  task automatic randomize_cells();
    for (int i = 0; i < COLS * ROWS; i++) cells[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    cells      = '0;
    cursor_en  = 1'b0;
    cursor_col = '0;
    cursor_row = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7, 7);
    total++;
    if ({pix.r, pix.g, pix.b} !== 12'h000) begin
      bad++;
      $display("FAIL reset_rgb got=%h exp=000", {pix.r, pix.g, pix.b});
    end
    total++;
    if ({pix.hsync_out, pix.vsync_out} !== 2'b11) begin
      bad++;
      $display("FAIL reset_sync got=%b exp=11", {pix.hsync_out, pix.vsync_out});
    end
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3, 3);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== 14'h3) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0003", i, obs_q[i]);
      end
    end
  endtask

  task automatic test_single_cell();
    obs_q.delete();
    exp_q.delete();
    cells = '0;
    cells[2*COLS + 1] = 1'b1;
    run_frame(1'b0, -1, -1);
    total++;
    if (img[7][5] !== 12'hFFF) begin
      bad++;
      $display("FAIL single_live got=%h exp=fff", img[7][5]);
    end
    cells[2*COLS + 1] = 1'b0;
    run_frame(1'b0, -1, -1);
    total++;
    if (img[7][5] !== 12'h000) begin
      bad++;
      $display("FAIL single_dead got=%h exp=000", img[7][5]);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL single_stream cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_corners();
    obs_q.delete();
    exp_q.delete();
    cells = '0;
    cells[0] = 1'b1;
    cells[COLS*ROWS - 1] = 1'b1;
    run_frame(1'b0, -1, -1);
    total++;
    if (img[1][1] !== 12'hFFF) begin
      bad++;
      $display("FAIL corner_first got=%h exp=fff", img[1][1]);
    end
    total++;
    if (img[GH-2][GW-2] !== 12'hFFF) begin
      bad++;
      $display("FAIL corner_last got=%h exp=fff", img[GH-2][GW-2]);
    end
    total++;
    if (img[GH-2][GW] !== 12'h000) begin
      bad++;
      $display("FAIL offgrid_right got=%h exp=000", img[GH-2][GW]);
    end
    total++;
    if (img[GH][GW-2] !== 12'h000) begin
      bad++;
      $display("FAIL offgrid_below got=%h exp=000", img[GH][GW-2]);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL corner_stream cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cursor_blink();
    logic [11:0] want;
    obs_q.delete();
    exp_q.delete();
    step(1'b1, 1'b1, 0, 0);
    randomize_cells();
    cells[3*COLS + 5] = 1'b1;
    cursor_en  = 1'b1;
    cursor_col = 3'd5;
    cursor_row = 3'd3;
    for (int f = 0; f < 5; f++) begin
      run_frame(1'b1, -1, -1);
      want = (((f / BF) % 2) == 0) ? 12'hF00 : 12'hFFF;
      total++;
      if (img[10][21] !== want) begin
        bad++;
        $display("FAIL blink frame=%0d got=%h exp=%h", f, img[10][21], want);
      end
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL blink_stream cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cursor_off_grid();
    int reds;
    obs_q.delete();
    exp_q.delete();
    randomize_cells();
    cursor_en  = 1'b1;
    cursor_col = 3'd2;
    cursor_row = 3'd6;
    run_frame(1'b0, -1, -1);
    reds = 0;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        if (img[yy][xx] === 12'hF00) reds++;
    total++;
    if (reds != 0) begin
      bad++;
      $display("FAIL cursor_offgrid red_pixels=%0d exp=0", reds);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL offgrid_stream cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    obs_q.delete();
    exp_q.delete();
    cells     = '1;
    cursor_en = 1'b0;
    run_frame(1'b1, 20, 10);
    total++;
    if (img[5][5] !== 12'hFFF) begin
      bad++;
      $display("FAIL pre_reset got=%h exp=fff", img[5][5]);
    end
    total++;
    if (img[13][25] !== 12'h000) begin
      bad++;
      $display("FAIL post_reset_black got=%h exp=000", img[13][25]);
    end
    run_frame(1'b0, -1, -1);
    total++;
    if (img[13][25] !== 12'hFFF) begin
      bad++;
      $display("FAIL next_frame got=%h exp=fff", img[13][25]);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL reset_stream cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      randomize_cells();
      cursor_en  = 1'($urandom_range(0, 1));
      cursor_col = 3'($urandom_range(0, 7));
      cursor_row = 3'($urandom_range(0, 7));
      run_frame(1'b0, -1, -1);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_stream cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_corners();
    test_cursor_blink();
    test_cursor_off_grid();
    test_mid_frame_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
